// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit driven by a shift-register scoreboard.
// Optional saturating stall counter enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_unit #(
    parameter int unsigned NUM_RS   = 2,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LD_STAGE = 2,
    localparam int unsigned SELW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     id_valid_i,
    input  logic [NUM_RS*REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0]        id_rd_i,
    input  logic                     id_regwrite_i,
    input  logic                     id_is_load_i,
    input  logic                     flush_i,
    output logic                     stall_o,
`ifdef FWD_STALL_CNT_EN
    output logic [31:0]              stall_cnt_o,
`endif
    output logic [NUM_RS*SELW-1:0]   ex_fwd_sel_o
);

    logic [DEPTH:0]          valid_q;
    logic [DEPTH:0]          ld_q;
    logic [REG_AW-1:0]       rd_q [DEPTH+1];
    logic [NUM_RS*SELW-1:0]  ex_fwd_sel_q;
    logic [NUM_RS*SELW-1:0]  sel_d;
    logic [NUM_RS-1:0]       found;
    logic [NUM_RS-1:0]       hazard;
    logic                    accept;

    // Scan youngest-first; the first hit per operand decides select and hazard.
    always_comb begin
        sel_d  = '0;
        found  = '0;
        hazard = '0;
        for (int i = 0; i < int'(NUM_RS); i++) begin
            for (int s = 0; s <= int'(DEPTH); s++) begin
                if (!found[i] && valid_q[s] && (id_rs_i[i*REG_AW +: REG_AW] != '0) &&
                    (rd_q[s] == id_rs_i[i*REG_AW +: REG_AW])) begin
                    found[i] = 1'b1;
                    if (s < int'(DEPTH)) begin
                        sel_d[i*SELW +: SELW] = SELW'(s + 1);
                    end
                    if (ld_q[s] && ((s + 1) < int'(LD_STAGE))) begin
                        hazard[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall_o      = id_valid_i & ~flush_i & (|hazard);
    assign accept       = id_valid_i & ~flush_i & ~stall_o;
    assign ex_fwd_sel_o = ex_fwd_sel_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= '0;
            ld_q         <= '0;
            ex_fwd_sel_q <= '0;
            for (int s = 0; s <= int'(DEPTH); s++) begin
                rd_q[s] <= '0;
            end
        end else begin
            for (int s = int'(DEPTH); s > 0; s--) begin
                valid_q[s] <= valid_q[s-1];
                ld_q[s]    <= ld_q[s-1];
                rd_q[s]    <= rd_q[s-1];
            end
            valid_q[0]   <= accept & id_regwrite_i & (id_rd_i != '0);
            ld_q[0]      <= id_is_load_i;
            rd_q[0]      <= id_rd_i;
            ex_fwd_sel_q <= accept ? sel_d : '0;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with default parameters.
// Stall-counter checks are compiled in only when FWD_STALL_CNT_EN is defined.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_is_load;
    logic        flush;
    logic        stall;
    logic [3:0]  ex_fwd_sel;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fwd_hazard_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_is_load_i  (id_is_load),
        .flush_i       (flush),
        .stall_o       (stall),
`ifdef FWD_STALL_CNT_EN
        .stall_cnt_o   (stall_cnt),
`endif
        .ex_fwd_sel_o  (ex_fwd_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one ID instruction and let combinational outputs settle.
    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic ld, input logic fl);
        id_valid    = v;
        id_rs       = {rs2, rs1};
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        flush       = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_sel", {28'd0, ex_fwd_sel}, 32'd0);
        #11 rst_n = 1'b1;
        step();
        check("post_rst_sel", {28'd0, ex_fwd_sel}, 32'd0);

        // ALU back-to-back
        issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
        check("b2b_stall", {31'd0, stall}, 32'd0);
        step();
        check("b2b_sel", {28'd0, ex_fwd_sel}, 32'h1);
        idle(3);
        check("idle_sel", {28'd0, ex_fwd_sel}, 32'd0);

        // Distance-2 forward on rs2
        issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        check("d2_stall", {31'd0, stall}, 32'd0);
        step();
        check("d2_sel", {28'd0, ex_fwd_sel}, 32'h8);
        idle(3);

        // Producer in the last entry is not forwarded
        issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        idle(2);
        issue(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("d3_sel", {28'd0, ex_fwd_sel}, 32'd0);
        idle(3);

        // Load-use: one stall cycle, then forward from stage 2
        issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_stall", {31'd0, stall}, 32'd1);
        step();
        check("lu_bubble_sel", {28'd0, ex_fwd_sel}, 32'd0);
        check("lu_retry_stall", {31'd0, stall}, 32'd0);
        step();
        check("lu_retry_sel", {28'd0, ex_fwd_sel}, 32'h2);
`ifdef FWD_STALL_CNT_EN
        check("lu_cnt", stall_cnt, 32'd1);
`endif
        idle(3);

        // Youngest producer wins
        issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("prio_sel", {28'd0, ex_fwd_sel}, 32'h1);
        idle(3);

        // Older load shadowed by a younger ALU write
        issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("shadow_stall", {31'd0, stall}, 32'd0);
        step();
        check("shadow_sel", {28'd0, ex_fwd_sel}, 32'h1);
        idle(3);

        // x0 never matches or stalls
        issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("x0_stall", {31'd0, stall}, 32'd0);
        step();
        check("x0_sel", {28'd0, ex_fwd_sel}, 32'd0);
        idle(3);

        // Flush beats stall; the flushed rd=7 must not enter the scoreboard
        issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        issue(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
        check("fl_stall", {31'd0, stall}, 32'd0);
        step();
        check("fl_sel", {28'd0, ex_fwd_sel}, 32'd0);
        issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("fl_next_stall", {31'd0, stall}, 32'd0);
        step();
        check("fl_next_sel", {28'd0, ex_fwd_sel}, 32'h2);
`ifdef FWD_STALL_CNT_EN
        check("fl_cnt", stall_cnt, 32'd1);
`endif
        idle(3);

        // Reset while a load-use stall is held
        issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd3, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("mid_stall", {31'd0, stall}, 32'd1);
        check("mid_sel", {28'd0, ex_fwd_sel}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("ar_stall", {31'd0, stall}, 32'd0);
        check("ar_sel", {28'd0, ex_fwd_sel}, 32'd0);
`ifdef FWD_STALL_CNT_EN
        check("ar_cnt", stall_cnt, 32'd0);
`endif
        #2 rst_n = 1'b1;
        step();
        check("pr_stall", {31'd0, stall}, 32'd0);
        step();
        check("pr_sel", {28'd0, ex_fwd_sel}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the in-order RISC-V pipeline.
- Keeps a shift-register scoreboard of in-flight destination registers from EX through the last forwarding stage.
- Computes forwarding selects for the instruction in ID and registers them, so they are valid when that instruction is in EX.
- Raises a load-use stall and inserts an EX bubble when load data cannot yet be forwarded.

Parameters:
- NUM_RS, 2: number of source operands per instruction.
- DEPTH, 2: number of forwarding stages after ID. Stage 0 = EX, 1 = EX/MEM, 2 = MEM/WB. Range 1..7.
- REG_AW, 5: register address width.
- LD_STAGE, 2: first stage index, 1..DEPTH, whose pipeline register holds load result data.
- SELW, derived, $clog2(DEPTH+1): width of one select field.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_RS*REG_AW  source registers of the ID instruction; operand i occupies bits [i*REG_AW +: REG_AW].
- id_rd  in  REG_AW  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is a load.
- flush  in  1  kill the ID instruction (branch or jump resolved in EX).
- stall  out  1  combinational; hold PC and IF/ID, bubble EX.
- ex_fwd_sel  out  NUM_RS*SELW  registered select per operand. 0 = register file; k = forward from stage k.
- stall_cnt  out  32  present only with FWD_STALL_CNT_EN.

Behaviour:
- Scoreboard: DEPTH+1 entries, index 0..DEPTH. Each entry holds {valid, rd, is_load}.
- Every rising clk, entry s+1 <= entry s and entry DEPTH is discarded. The pipeline never freezes; stalls only inject bubbles.
- Entry 0 load value:
  - {1, id_rd, id_is_load} when id_valid & id_regwrite & (id_rd != 0) & !stall & !flush.
  - Otherwise invalid.
- Match for operand i at stage s: entry s valid & entry s rd == rs_i & rs_i != 0.
- Youngest match wins, i.e. lowest s.
- Next select for operand i:
  - s+1 if the youngest match has s+1 <= DEPTH.
  - 0 if there is no match.
  - Entry DEPTH never forwards; the register file is written-before-read.
- Load-use hazard: for any operand, the youngest match is a load and s+1 < LD_STAGE.
- stall = id_valid & !flush & hazard on any operand. Combinational, same cycle.
- On stall or flush: ex_fwd_sel next = all zero, and a bubble enters entry 0.
- Otherwise ex_fwd_sel next = computed selects.
- When id_valid = 0: no stall, ex_fwd_sel next = 0, bubble inserted.
- flush and a hazard in the same cycle: flush wins, stall = 0.
- Reset (async assert, any time, including mid-stall):
  - All entries invalid, ex_fwd_sel = 0, stall_cnt = 0.
  - stall deasserts immediately because the scoreboard is empty.
  - Release is synchronous to clk through the existing reset synchroniser; no extra logic in this block.
- An older producer shadowed by a younger match to the same register is ignored, even when the older one is a load.
- x0 is never matched, never stalls, and never enters the scoreboard.

Optional Feature:
- Macro: FWD_STALL_CNT_EN.
- Defined: 32-bit stall_cnt port.
  - Increments on each clk edge where stall = 1.
  - Saturates at 0xFFFF_FFFF.
  - Cleared only by rst_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- All cases use defaults (NUM_RS=2, DEPTH=2, LD_STAGE=2).
- ALU back-to-back: issue add x5 (rd=5), then rs1=5, rs2=6 -> stall=0; next cycle ex_fwd_sel = {rs2:0, rs1:1}.
- Distance-2 forward: add x5, unrelated instruction, then rs2=5 -> ex_fwd_sel rs2 = 2, rs1 = 0, no stall.
- Load-use: lw x7, then rs1=7 -> stall=1 for exactly one cycle with ex_fwd_sel=0; retried instruction gets ex_fwd_sel rs1 = 2, stall=0.
- Priority and x0:
  - add x5 followed by add x5, then consumer rs1=5 -> select 1 (youngest).
  - Consumer rs1=0 after add x0 -> select 0, no stall.
- Flush vs stall: lw x7, then rs1=7 with flush=1 same cycle -> stall=0, bubble inserted, stall_cnt unchanged.
- Reset mid-stall: hold a load-use stall, pulse rst_n low -> stall, ex_fwd_sel and stall_cnt go to 0 without a clk edge; first post-reset consumer of x7 gets select 0.
